// File: rtl/uart_transmitter.sv
// UART serial transmitter: 5-8 data bits LSB-first, optional parity, 1 or 2
// stop bits, bit period of clockDivisor+1 clk cycles, one-entry holding
// register, forced break output and a sticky overflow flag.
module uart_transmitter #(
  parameter int unsigned CLOCK_DIVISOR_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     dataBits,
  input  logic                           hasParity,
  input  logic [1:0]                     parityMode,
  input  logic                           extraStopBit,
  input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
  input  logic [7:0]                     dataIn,
  input  logic                           sendData,
  input  logic                           sendBreak,
  input  logic                           clearOverflow,
  output logic                           tx,
  output logic                           ready,
  output logic                           busy,
  output logic                           dataSent,
  output logic                           overflow
);

  localparam int unsigned CountW = CLOCK_DIVISOR_WIDTH;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;
  localparam logic [2:0] MARK   = 3'd6;

  logic [2:0]        state, stateNext;
  logic [CountW-1:0] bitCount, countNext;
  logic [CountW-1:0] divisor, divisorNext;
  logic [2:0]        bitIndex, bitIndexNext;
  logic [2:0]        lastIndex, lastIndexNext;
  logic              stopIndex, stopIndexNext;
  logic [7:0]        frameData, frameDataNext;
  logic              frameParity, frameParityNext;
  logic              parityBit, parityBitNext;
  logic              twoStop, twoStopNext;
  logic [7:0]        holdData, holdDataNext;
  logic              readyNext, overflowNext;
  logic              txNext, busyNext, dataSentNext;
  logic              launch, bitDone;
  logic [7:0]        launchMask, launchData;
  logic              launchParity;

  // Only the active data bits of the queued byte are sent and enter the parity.
  assign launchMask = 8'(8'hFF >> (2'd3 - dataBits));
  assign launchData = holdData & launchMask;

  // Parity bit for the frame about to launch, from the live config inputs.
  always_comb begin
    case (parityMode)
      2'b00:   launchParity = 1'b0;
      2'b11:   launchParity = 1'b1;
      2'b01:   launchParity = ^launchData;
      default: launchParity = ~^launchData;
    endcase
  end

  // Next-state, datapath and registered-output values.
  always_comb begin
    stateNext       = state;
    countNext       = bitCount;
    divisorNext     = divisor;
    bitIndexNext    = bitIndex;
    lastIndexNext   = lastIndex;
    stopIndexNext   = stopIndex;
    frameDataNext   = frameData;
    frameParityNext = frameParity;
    parityBitNext   = parityBit;
    twoStopNext     = twoStop;
    holdDataNext    = holdData;
    readyNext       = ready;
    overflowNext    = overflow;
    txNext          = 1'b1;
    busyNext        = 1'b0;
    dataSentNext    = 1'b0;
    launch          = 1'b0;
    bitDone         = (bitCount == divisor);

    case (state)
      IDLE: begin
        if (sendBreak) begin
          stateNext = BREAK;
        end else if (!ready) begin
          launch = 1'b1;
        end
      end
      START: begin
        if (bitDone) begin
          stateNext    = DATA;
          countNext    = '0;
          bitIndexNext = '0;
        end else begin
          countNext = bitCount + CountW'(1);
        end
      end
      DATA: begin
        if (bitDone) begin
          countNext = '0;
          if (bitIndex == lastIndex) begin
            stateNext     = frameParity ? PARITY : STOP;
            stopIndexNext = 1'b0;
          end else begin
            bitIndexNext = bitIndex + 3'd1;
          end
        end else begin
          countNext = bitCount + CountW'(1);
        end
      end
      PARITY: begin
        if (bitDone) begin
          stateNext     = STOP;
          countNext     = '0;
          stopIndexNext = 1'b0;
        end else begin
          countNext = bitCount + CountW'(1);
        end
      end
      STOP: begin
        if (bitDone) begin
          countNext = '0;
          if (twoStop && !stopIndex) begin
            stopIndexNext = 1'b1;
          end else if (!ready && !sendBreak) begin
            launch = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end else begin
          countNext = bitCount + CountW'(1);
        end
      end
      BREAK: begin
        if (!sendBreak) begin
          stateNext   = MARK;
          countNext   = '0;
          divisorNext = clockDivisor;
        end
      end
      MARK: begin
        if (bitDone) begin
          countNext = '0;
          if (!ready && !sendBreak) begin
            launch = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end else begin
          countNext = bitCount + CountW'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        countNext = '0;
      end
    endcase

    // Frame launch: latch the queued byte and the whole frame configuration.
    if (launch) begin
      stateNext       = START;
      countNext       = '0;
      divisorNext     = clockDivisor;
      frameDataNext   = launchData;
      lastIndexNext   = 3'(dataBits) + 3'd4;
      frameParityNext = hasParity;
      parityBitNext   = launchParity;
      twoStopNext     = extraStopBit;
      readyNext       = 1'b1;
    end

    // Host write port; an overflow event beats a simultaneous clear.
    if (sendData) begin
      if (ready) begin
        readyNext    = 1'b0;
        holdDataNext = dataIn;
      end else begin
        overflowNext = 1'b1;
      end
    end else if (clearOverflow) begin
      overflowNext = 1'b0;
    end

    case (stateNext)
      START, BREAK: txNext = 1'b0;
      DATA:         txNext = frameDataNext[bitIndexNext];
      PARITY:       txNext = parityBitNext;
      default:      txNext = 1'b1;
    endcase
    busyNext     = (stateNext != IDLE);
    dataSentNext = (stateNext == STOP) && (countNext == divisorNext) &&
                   (stopIndexNext == twoStopNext);
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bitCount    <= '0;
      divisor     <= '0;
      bitIndex    <= '0;
      lastIndex   <= '0;
      stopIndex   <= 1'b0;
      frameData   <= '0;
      frameParity <= 1'b0;
      parityBit   <= 1'b0;
      twoStop     <= 1'b0;
      holdData    <= '0;
      ready       <= 1'b1;
      overflow    <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      dataSent    <= 1'b0;
    end else begin
      state       <= stateNext;
      bitCount    <= countNext;
      divisor     <= divisorNext;
      bitIndex    <= bitIndexNext;
      lastIndex   <= lastIndexNext;
      stopIndex   <= stopIndexNext;
      frameData   <= frameDataNext;
      frameParity <= frameParityNext;
      parityBit   <= parityBitNext;
      twoStop     <= twoStopNext;
      holdData    <= holdDataNext;
      ready       <= readyNext;
      overflow    <= overflowNext;
      tx          <= txNext;
      busy        <= busyNext;
      dataSent    <= dataSentNext;
    end
  end

endmodule
